// File: rtl/tlb_op_sequencer.sv
// Multi-cycle executor for TLBR/TLBWI/TLBWR/TLBP against a synchronous-read TLB array.
// Also owns the CP0 Random register and returns TLBR/TLBP results to CP0 as one-cycle pulses.
module tlb_op_sequencer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int CONF_W  = 86
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  output logic              op_ready,
  output logic              busy,
  input  logic              flush,
  input  logic [IDX_W-1:0]  cp0_index,
  input  logic [IDX_W-1:0]  cp0_wired,
  input  logic [CONF_W-1:0] cp0_tlb_conf,
  output logic [IDX_W-1:0]  tlb_addr,
  output logic              tlb_ren,
  input  logic [CONF_W-1:0] tlb_rdata,
  output logic              tlb_wen,
  output logic [CONF_W-1:0] tlb_wdata,
  output logic              cp0_tlbr,
  output logic [CONF_W-1:0] tlbr_conf,
  output logic              cp0_tlbp,
  output logic              miss_probe,
  output logic [IDX_W-1:0]  matched_index_probe,
  output logic [IDX_W-1:0]  random_index,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where op_valid & op_ready are both high;
  // op_ready is only offered in IDLE, outside reset, and never in a flush cycle.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_SCAN = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W:0]   SCAN_END = (IDX_W + 1)'(ENTRIES);

  // Entry layout: {VPN2[18:0], G, ASID[7:0], Lo0, Lo1}
  localparam int VPN_HI  = CONF_W - 1;
  localparam int G_BIT   = CONF_W - 20;
  localparam int ASID_HI = CONF_W - 21;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CONF_W-1:0]   conf_q;
  logic [IDX_W:0]      scan_cnt;
  logic [IDX_W:0]      scan_prev;
  logic                accept;
  logic                entry_match;
  logic                probe_load;
  logic                probe_hit;

  assign op_ready  = rst_n & (state == S_IDLE) & ~flush;
  assign accept    = op_valid & op_ready;
  assign busy      = (state != S_IDLE);
  assign tlb_wdata = conf_q;
  assign dbg_state = state;
  assign scan_prev = scan_cnt - 1'b1;

  // tlb_rdata holds the entry read in the previous scan cycle
  assign entry_match = (tlb_rdata[VPN_HI -: 19] == conf_q[VPN_HI -: 19]) &&
                       (tlb_rdata[G_BIT] || (tlb_rdata[ASID_HI -: 8] == conf_q[ASID_HI -: 8]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      op_q                <= '0;
      idx_q               <= '0;
      conf_q              <= '0;
      scan_cnt            <= '0;
      tlbr_conf           <= '0;
      miss_probe          <= 1'b0;
      matched_index_probe <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= op_code;
        idx_q    <= (op_code == OP_TLBWR) ? random_index : cp0_index;
        conf_q   <= cp0_tlb_conf;
        scan_cnt <= '0;
      end else if (state == S_SCAN) begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (state == S_CAP && !flush) begin
        tlbr_conf <= tlb_rdata;
      end
      if (probe_load) begin
        miss_probe          <= ~probe_hit;
        matched_index_probe <= probe_hit ? scan_prev[IDX_W-1:0] : '0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    tlb_ren    = 1'b0;
    tlb_wen    = 1'b0;
    tlb_addr   = idx_q;
    done       = 1'b0;
    cp0_tlbr   = 1'b0;
    cp0_tlbp   = 1'b0;
    probe_load = 1'b0;
    probe_hit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_TLBR: state_nxt = S_RD;
            OP_TLBP: state_nxt = S_SCAN;
            default: state_nxt = S_WR;
          endcase
        end
      end
      S_RD: begin
        tlb_ren   = 1'b1;
        state_nxt = flush ? S_IDLE : S_CAP;
      end
      S_CAP: begin
        state_nxt = flush ? S_IDLE : S_DONE;
      end
      S_WR: begin
        tlb_wen   = ~flush;
        state_nxt = flush ? S_IDLE : S_DONE;
      end
      S_SCAN: begin
        // Read of entry k overlaps the compare of entry k-1; cycle ENTRIES only compares.
        tlb_addr = scan_cnt[IDX_W-1:0];
        tlb_ren  = (scan_cnt < SCAN_END);
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (scan_cnt != '0 && entry_match) begin
          state_nxt  = S_DONE;
          probe_load = 1'b1;
          probe_hit  = 1'b1;
        end else if (scan_cnt == SCAN_END) begin
          state_nxt  = S_DONE;
          probe_load = 1'b1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        cp0_tlbr  = (op_q == OP_TLBR);
        cp0_tlbp  = (op_q == OP_TLBP);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Random free-runs; wraps to the top once it reaches or falls below Wired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_index <= LAST_IDX;
    end else if (random_index <= cp0_wired) begin
      random_index <= LAST_IDX;
    end else begin
      random_index <= random_index - 1'b1;
    end
  end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Bench for tlb_op_sequencer: TLB array model, Random-register model and a probe reference
// computed from the array contents the bench itself wrote.
module tb_tlb_op_sequencer;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CONF_W  = 86;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_valid;
  logic [1:0]        op_code;
  logic              op_ready;
  logic              busy;
  logic              flush;
  logic [IDX_W-1:0]  cp0_index;
  logic [IDX_W-1:0]  cp0_wired;
  logic [CONF_W-1:0] cp0_tlb_conf;
  logic [IDX_W-1:0]  tlb_addr;
  logic              tlb_ren;
  logic [CONF_W-1:0] tlb_rdata;
  logic              tlb_wen;
  logic [CONF_W-1:0] tlb_wdata;
  logic              cp0_tlbr;
  logic [CONF_W-1:0] tlbr_conf;
  logic              cp0_tlbp;
  logic              miss_probe;
  logic [IDX_W-1:0]  matched_index_probe;
  logic [IDX_W-1:0]  random_index;
  logic              done;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  tlb_op_sequencer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .CONF_W(CONF_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .busy(busy), .flush(flush), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
    .cp0_tlb_conf(cp0_tlb_conf), .tlb_addr(tlb_addr), .tlb_ren(tlb_ren), .tlb_rdata(tlb_rdata),
    .tlb_wen(tlb_wen), .tlb_wdata(tlb_wdata), .cp0_tlbr(cp0_tlbr), .tlbr_conf(tlbr_conf),
    .cp0_tlbp(cp0_tlbp), .miss_probe(miss_probe), .matched_index_probe(matched_index_probe),
    .random_index(random_index), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  logic [CONF_W-1:0] mem [ENTRIES];
  always @(posedge clk) begin
    if (tlb_ren) tlb_rdata <= mem[tlb_addr];
    if (tlb_wen) mem[tlb_addr] <= tlb_wdata;
  end

  // ---------------- reference model ----------------
  logic [CONF_W-1:0] ref_mem [ENTRIES];
  logic [IDX_W-1:0]  exp_rand;

  function automatic logic [IDX_W-1:0] next_random(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] w);
    return (r <= w) ? IDX_W'(ENTRIES - 1) : r - 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_rand <= IDX_W'(ENTRIES - 1);
    else exp_rand <= next_random(exp_rand, cp0_wired);
  end

  function automatic void ref_probe(input logic [CONF_W-1:0] key, output logic hit, output logic [IDX_W-1:0] idx);
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && ref_mem[i][85:67] == key[85:67] && (ref_mem[i][66] || ref_mem[i][65:58] == key[65:58])) begin
        hit = 1'b1;
        idx = i[IDX_W-1:0];
      end
    end
  endfunction

  function automatic logic [CONF_W-1:0] rand_conf();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CONF_W-1:0];
  endfunction

  function automatic logic [CONF_W-1:0] make_conf(input logic [18:0] vpn, input logic g, input logic [7:0] asid);
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return {vpn, g, asid, t[57:0]};
  endfunction

  // ---------------- driver ----------------
  int                r_done_lat, r_done_cnt, r_wen_lat, r_ren_lat, r_tlbr_lat, r_tlbp_lat;
  logic [IDX_W-1:0]  r_wen_addr, r_ren_addr, r_midx, r_rand_acc;
  logic [CONF_W-1:0] r_wen_data, r_rconf;
  logic              r_miss, r_ready, r_ready_busy, r_busy_after;

  // Issues one op at a negedge and records what the DUT does over the following 22 cycles.
  task automatic run_op(input logic [1:0] code, input logic [IDX_W-1:0] idx,
                        input logic [CONF_W-1:0] conf, input int flush_n);
    @(negedge clk);
    op_valid = 1'b1; op_code = code; cp0_index = idx; cp0_tlb_conf = conf; flush = 1'b0;
    #1;
    r_ready = op_ready; r_rand_acc = exp_rand;
    r_done_lat = -1; r_done_cnt = 0; r_wen_lat = -1; r_ren_lat = -1; r_tlbr_lat = -1; r_tlbp_lat = -1;
    r_busy_after = 1'bx; r_ready_busy = 1'bx;
    @(negedge clk);
    op_valid = 1'b0; cp0_index = IDX_W'($urandom()); cp0_tlb_conf = rand_conf();
    for (int n = 1; n <= 22; n++) begin
      flush = (n == flush_n);
      #1;
      if (n == 1) r_ready_busy = op_ready;
      if (tlb_wen && r_wen_lat < 0) begin r_wen_lat = n; r_wen_addr = tlb_addr; r_wen_data = tlb_wdata; end
      if (tlb_ren && r_ren_lat < 0) begin r_ren_lat = n; r_ren_addr = tlb_addr; end
      if (done) begin r_done_cnt++; r_done_lat = n; end
      if (cp0_tlbr) begin r_tlbr_lat = n; r_rconf = tlbr_conf; end
      if (cp0_tlbp) begin r_tlbp_lat = n; r_miss = miss_probe; r_midx = matched_index_probe; end
      if (n == flush_n + 1) r_busy_after = busy;
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  task automatic write_entry(input logic [IDX_W-1:0] idx, input logic [CONF_W-1:0] c);
    run_op(2'b01, idx, c, -1);
    ref_mem[idx] = c;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; op_valid = 1'b0; op_code = '0; flush = 1'b0;
    cp0_index = '0; cp0_wired = '0; cp0_tlb_conf = '0;
    #12;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rst_op_ready got %0b exp 0", op_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (random_index !== 4'd15) begin errors++; $display("FAIL rst_random got %0d exp 15", random_index); end
    checks++; if ({tlb_ren, tlb_wen, done, cp0_tlbr, cp0_tlbp, miss_probe} !== 6'b0) begin
      errors++; $display("FAIL rst_strobes got %b exp 000000", {tlb_ren, tlb_wen, done, cp0_tlbr, cp0_tlbp, miss_probe}); end
    checks++; if (tlbr_conf !== '0 || matched_index_probe !== '0) begin
      errors++; $display("FAIL rst_results got %h/%0d exp 0/0", tlbr_conf, matched_index_probe); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b exp 1", op_ready); end
  endtask

  task automatic test_write;
    logic [CONF_W-1:0] c;
    for (int i = 0; i < ENTRIES; i++) begin
      c = rand_conf();
      run_op(2'b01, IDX_W'(i), c, -1);
      ref_mem[i] = c;
      checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL wi_ready got %0b exp 1", r_ready); end
      checks++; if (r_ready_busy !== 1'b0) begin errors++; $display("FAIL wi_ready_busy got %0b exp 0", r_ready_busy); end
      checks++; if (r_wen_lat !== 1) begin errors++; $display("FAIL wi_wen_lat got %0d exp 1", r_wen_lat); end
      checks++; if (r_wen_addr !== IDX_W'(i)) begin errors++; $display("FAIL wi_addr got %0d exp %0d", r_wen_addr, i); end
      checks++; if (r_wen_data !== c) begin errors++; $display("FAIL wi_data got %h exp %h", r_wen_data, c); end
      checks++; if (r_done_lat !== 2 || r_done_cnt !== 1) begin
        errors++; $display("FAIL wi_done got lat %0d cnt %0d exp lat 2 cnt 1", r_done_lat, r_done_cnt); end
      checks++; if (r_ren_lat !== -1 || r_tlbr_lat !== -1 || r_tlbp_lat !== -1) begin
        errors++; $display("FAIL wi_unused got ren %0d tlbr %0d tlbp %0d exp none", r_ren_lat, r_tlbr_lat, r_tlbp_lat); end
    end
  endtask

  task automatic test_write_read;
    logic [IDX_W-1:0] idx;
    logic [CONF_W-1:0] x;
    x = rand_conf();
    write_entry(4'd5, x);
    checks++; if (r_wen_lat !== 1 || r_wen_addr !== 4'd5) begin
      errors++; $display("FAIL wr5_wen got lat %0d addr %0d exp 1/5", r_wen_lat, r_wen_addr); end
    for (int i = 0; i < 12; i++) begin
      idx = (i == 0) ? 4'd5 : IDX_W'($urandom_range(0, ENTRIES - 1));
      if (i > 0 && $urandom_range(0, 1) == 1) write_entry(IDX_W'($urandom_range(0, ENTRIES - 1)), rand_conf());
      run_op(2'b00, idx, rand_conf(), -1);
      checks++; if (r_ren_lat !== 1 || r_ren_addr !== idx) begin
        errors++; $display("FAIL tlbr_ren got lat %0d addr %0d exp 1/%0d", r_ren_lat, r_ren_addr, idx); end
      checks++; if (r_tlbr_lat !== 3 || r_done_lat !== 3 || r_done_cnt !== 1) begin
        errors++; $display("FAIL tlbr_lat got %0d done %0d cnt %0d exp 3/3/1", r_tlbr_lat, r_done_lat, r_done_cnt); end
      checks++; if (r_rconf !== ref_mem[idx]) begin
        errors++; $display("FAIL tlbr_conf idx %0d got %h exp %h", idx, r_rconf, ref_mem[idx]); end
      checks++; if (r_wen_lat !== -1 || r_tlbp_lat !== -1) begin
        errors++; $display("FAIL tlbr_unused got wen %0d tlbp %0d exp none", r_wen_lat, r_tlbp_lat); end
    end
  endtask

  task automatic test_probe_directed;
    logic [18:0] keys [4];
    logic [7:0]  asids [4];
    int          exp_lat [4];
    logic [IDX_W-1:0] exp_idx [4];
    logic        exp_miss [4];
    for (int i = 0; i < ENTRIES; i++) write_entry(IDX_W'(i), make_conf(19'h100 + 19'(i), 1'b0, 8'h05));
    write_entry(4'd3, make_conf(19'h2AAAA, 1'b0, 8'h01));
    write_entry(4'd9, make_conf(19'h2AAAA, 1'b1, 8'h07));
    keys[0] = 19'h2AAAA; asids[0] = 8'h02; exp_lat[0] = 12; exp_idx[0] = 4'd9;  exp_miss[0] = 1'b0;
    keys[1] = 19'h7FFFF; asids[1] = 8'h05; exp_lat[1] = 18; exp_idx[1] = 4'd0;  exp_miss[1] = 1'b1;
    keys[2] = 19'h100;   asids[2] = 8'h05; exp_lat[2] = 3;  exp_idx[2] = 4'd0;  exp_miss[2] = 1'b0;
    keys[3] = 19'h10F;   asids[3] = 8'h05; exp_lat[3] = 18; exp_idx[3] = 4'd15; exp_miss[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      run_op(2'b11, 4'd0, make_conf(keys[t], 1'b0, asids[t]), -1);
      checks++; if (r_tlbp_lat !== exp_lat[t] || r_done_lat !== exp_lat[t] || r_done_cnt !== 1) begin
        errors++; $display("FAIL tlbp_dir%0d_lat got %0d done %0d cnt %0d exp %0d", t, r_tlbp_lat, r_done_lat, r_done_cnt, exp_lat[t]); end
      checks++; if (r_miss !== exp_miss[t] || r_midx !== exp_idx[t]) begin
        errors++; $display("FAIL tlbp_dir%0d_res got miss %0b idx %0d exp %0b/%0d", t, r_miss, r_midx, exp_miss[t], exp_idx[t]); end
      checks++; if (r_tlbr_lat !== -1 || r_wen_lat !== -1) begin
        errors++; $display("FAIL tlbp_dir%0d_unused got tlbr %0d wen %0d exp none", t, r_tlbr_lat, r_wen_lat); end
    end
  endtask

  task automatic test_probe_random;
    logic [18:0] vpns [3];
    logic [CONF_W-1:0] key;
    logic e_hit;
    logic [IDX_W-1:0] e_idx;
    int e_lat;
    vpns[0] = 19'h11; vpns[1] = 19'h22; vpns[2] = 19'h33;
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 5; w++)
        write_entry(IDX_W'($urandom_range(0, ENTRIES - 1)),
                    make_conf(vpns[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), 8'($urandom_range(1, 2))));
      key = make_conf(vpns[$urandom_range(0, 2)], 1'b0, 8'($urandom_range(1, 2)));
      ref_probe(key, e_hit, e_idx);
      e_lat = e_hit ? 3 + int'(e_idx) : 18;
      run_op(2'b11, 4'd0, key, -1);
      checks++; if (r_tlbp_lat !== e_lat || r_done_cnt !== 1) begin
        errors++; $display("FAIL tlbp_rnd_lat got %0d cnt %0d exp %0d", r_tlbp_lat, r_done_cnt, e_lat); end
      checks++; if (r_miss !== ~e_hit || r_midx !== e_idx) begin
        errors++; $display("FAIL tlbp_rnd_res got miss %0b idx %0d exp %0b/%0d", r_miss, r_midx, ~e_hit, e_idx); end
    end
  endtask

  task automatic test_random_reg;
    logic [IDX_W-1:0] seq [8];
    logic [CONF_W-1:0] c;
    seq[0] = 15; seq[1] = 14; seq[2] = 13; seq[3] = 12; seq[4] = 15; seq[5] = 14; seq[6] = 13; seq[7] = 12;
    @(negedge clk);
    cp0_wired = 4'd12;
    for (int w = 0; w < 20 && exp_rand != 4'd15; w++) @(negedge clk);
    @(negedge clk);
    for (int w = 0; w < 20 && exp_rand != 4'd15; w++) @(negedge clk);
    checks++; if (exp_rand !== 4'd15) begin errors++; $display("FAIL rand_sync timeout got %0d exp 15", exp_rand); end
    for (int j = 0; j < 8; j++) begin
      #1;
      checks++; if (random_index !== seq[j]) begin
        errors++; $display("FAIL rand_seq%0d got %0d exp %0d", j, random_index, seq[j]); end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      c = rand_conf();
      run_op(2'b10, IDX_W'($urandom()), c, -1);
      ref_mem[r_rand_acc] = c;
      checks++; if (r_wen_lat !== 1 || r_wen_addr !== r_rand_acc) begin
        errors++; $display("FAIL tlbwr_addr got lat %0d addr %0d exp 1/%0d", r_wen_lat, r_wen_addr, r_rand_acc); end
      checks++; if (r_wen_data !== c || r_done_lat !== 2) begin
        errors++; $display("FAIL tlbwr_data got %h done %0d exp %h/2", r_wen_data, r_done_lat, c); end
    end
    for (int j = 0; j < 24; j++) begin
      #1;
      checks++; if (random_index !== exp_rand) begin errors++; $display("FAIL rand_track got %0d exp %0d", random_index, exp_rand); end
      @(negedge clk);
    end
    cp0_wired = 4'd15;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (random_index !== 4'd15) begin errors++; $display("FAIL rand_hold got %0d exp 15", random_index); end
      @(negedge clk);
    end
    cp0_wired = 4'd0;
  endtask

  task automatic test_flush;
    logic [CONF_W-1:0] a;
    a = rand_conf();
    write_entry(4'd6, a);
    run_op(2'b01, 4'd6, ~a, 1);
    checks++; if (r_wen_lat !== -1) begin errors++; $display("FAIL flush_wr_wen got lat %0d exp none", r_wen_lat); end
    checks++; if (r_done_cnt !== 0) begin errors++; $display("FAIL flush_wr_done got %0d exp 0", r_done_cnt); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL flush_wr_idle got busy %0b exp 0", r_busy_after); end
    run_op(2'b00, 4'd6, rand_conf(), -1);
    checks++; if (r_rconf !== ref_mem[6]) begin errors++; $display("FAIL flush_wr_kept got %h exp %h", r_rconf, ref_mem[6]); end
    run_op(2'b11, 4'd0, make_conf(19'h7FFFF, 1'b0, 8'h00), 5);
    checks++; if (r_tlbp_lat !== -1 || r_done_cnt !== 0) begin
      errors++; $display("FAIL flush_scan_pulse got tlbp %0d done %0d exp none", r_tlbp_lat, r_done_cnt); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL flush_scan_idle got busy %0b exp 0", r_busy_after); end
  endtask

  task automatic test_reset_mid_scan;
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b11; cp0_tlb_conf = make_conf(19'h7FFFF, 1'b0, 8'h00);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rscan_busy_before got %0b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || op_ready !== 1'b0) begin
      errors++; $display("FAIL rscan_idle got busy %0b ready %0b exp 0/0", busy, op_ready); end
    checks++; if (random_index !== 4'd15) begin errors++; $display("FAIL rscan_random got %0d exp 15", random_index); end
    checks++; if ({tlb_ren, tlb_wen, done, cp0_tlbr, cp0_tlbp} !== 5'b0) begin
      errors++; $display("FAIL rscan_pulses got %b exp 00000", {tlb_ren, tlb_wen, done, cp0_tlbr, cp0_tlbp}); end
    checks++; if (tlbr_conf !== '0 || miss_probe !== 1'b0 || matched_index_probe !== '0) begin
      errors++; $display("FAIL rscan_results got %h/%0b/%0d exp 0/0/0", tlbr_conf, miss_probe, matched_index_probe); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rscan_ready got %0b exp 1", op_ready); end
    run_op(2'b00, 4'd6, rand_conf(), -1);
    checks++; if (r_rconf !== ref_mem[6] || r_tlbr_lat !== 3) begin
      errors++; $display("FAIL rscan_after got %h lat %0d exp %h/3", r_rconf, r_tlbr_lat, ref_mem[6]); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write();
    test_write_read();
    test_probe_directed();
    test_probe_random();
    test_random_reg();
    test_flush();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlb_op_sequencer.md
# tlb_op_sequencer

Multi-cycle sequencer that executes the MIPS32 TLB instructions (TLBR, TLBWI, TLBWR, TLBP) against a 16-entry, single-port, synchronous-read TLB array on behalf of the pipeline. It sits between the memory-stage instruction decode and the CP0/TLB pair. It snapshots the CP0 TLB configuration word, owns the Random register, and returns TLBR/TLBP results to CP0 as one-cycle pulses. Only one operation is in flight; the pipeline stalls while `busy`.

## Interface
- `ENTRIES`, 16: TLB entry count (power of two).
- `IDX_W`, 4: index width, log2(ENTRIES).
- `CONF_W`, 86: entry width; format {VPN2[18:0], G, ASID[7:0], Lo0[28:0], Lo1[28:0]}, bit 66 = G, [65:58] = ASID.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `op_valid` in 1: TLB instruction request.
- `op_code` in 2: 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
- `op_ready` out 1: request accepted when `op_valid & op_ready`.
- `busy` out 1: state != IDLE.
- `flush` in 1: exception/pipeline flush; aborts current op.
- `cp0_index` in IDX_W: CP0 Index[3:0].
- `cp0_wired` in IDX_W: CP0 Wired[3:0].
- `cp0_tlb_conf` in CONF_W: CP0 EntryHi/EntryLo packed word.
- `tlb_addr` out IDX_W: array address.
- `tlb_ren` out 1: array read strobe; data on `tlb_rdata` next cycle.
- `tlb_rdata` in CONF_W: array read data.
- `tlb_wen` out 1: array write strobe.
- `tlb_wdata` out CONF_W: array write data.
- `cp0_tlbr` out 1: pulse; CP0 loads `tlbr_conf`.
- `tlbr_conf` out CONF_W: entry read by TLBR.
- `cp0_tlbp` out 1: pulse; CP0 loads probe result.
- `miss_probe` out 1: TLBP found no match.
- `matched_index_probe` out IDX_W: TLBP matching index.
- `random_index` out IDX_W: current Random register.
- `done` out 1: pulse, op completed (not asserted on abort).

## Operation
- States: IDLE, RD, CAP, WR, SCAN, DONE.
- `op_ready = (state==IDLE) & ~flush`. On accept latch op_code, `cp0_tlb_conf` (snapshot), and target index: `cp0_index` for TLBR/TLBWI, `random_index` for TLBWR. Later CP0 changes are ignored.
- TLBR: IDLE→RD (`tlb_ren`=1, addr=index) → CAP (register `tlb_rdata` into `tlbr_conf`) → DONE (`cp0_tlbr`=1, `done`=1) → IDLE.
- TLBWI/TLBWR: IDLE→WR (`tlb_wen`=1, addr=index, wdata=snapshot) → DONE (`done`=1) → IDLE.
- TLBP: SCAN issues a read of entry k in scan cycle k (k=0..15) and compares the entry returned for k-1 in the same cycle. Match rule: VPN2 equal AND (entry G OR entry ASID == snapshot ASID). First (lowest) matching index wins; scan stops on match. After entry 15 compares without a match, the result is a miss. DONE: `cp0_tlbp`=1, `done`=1, `miss_probe`/`matched_index_probe` registered. On a miss, `matched_index_probe`=0.
- Random: resets to ENTRIES-1. Decrements every cycle. If the value is ≤ `cp0_wired`, or below it after a Wired change, it loads ENTRIES-1 next cycle. With `cp0_wired`=15 it holds 15. It runs regardless of FSM state.
- Flush in any non-IDLE state: next state IDLE. `tlb_wen` is gated low combinationally in that cycle. No `done`/`cp0_tlbr`/`cp0_tlbp`. Flush in DONE does not suppress the pulses already in that cycle.
- Unused strobes are 0. `tlb_addr` and `tlb_wdata` are don't-care when no strobe is active.

## Timing
- Accept at cycle T.
- TLBR: ren at T+1, DONE at T+3.
- TLBW*: wen at T+1, DONE at T+2.
- TLBP hit at k: DONE at T+3+k. Miss: DONE at T+18.
- DONE lasts exactly one cycle. A new op can be accepted at DONE+1.
- Reset (asynchronous, any state): state IDLE. `random_index`=15. All other outputs 0 (`op_ready`=1 once `rst_n` deasserts). `tlbr_conf`=0, `miss_probe`=0, `matched_index_probe`=0. Reset mid-op aborts with no further array writes.

## Test plan
- TLBWI with `cp0_index`=5 and conf=X, then TLBR with index 5 → `tlb_wen` at T+1 addr 5; `cp0_tlbr` at T'+3 with `tlbr_conf`=X.
- TLBP, entries 3 and 9 both match VPN2 (entry 3 ASID mismatch, G=0; entry 9 G=1) → `matched_index_probe`=9, `miss_probe`=0, DONE at T+12.
- TLBP with no match → `miss_probe`=1, index 0, `cp0_tlbp` at T+18.
- `cp0_wired`=12 → `random_index` cycles 15,14,13,12,15…; TLBWR writes the value sampled at the accept cycle.
- `flush` during WR cycle → `tlb_wen`=0, no `done`, IDLE next cycle. `flush` mid-SCAN → no `cp0_tlbp`.
- `rst_n` low during SCAN → IDLE immediately, `random_index`=15, all pulses 0.
